// File: rtl/iob_asym_fifo_ctrl.sv
// Pointer and flag controller for a synchronous FIFO whose write and read words differ in width
// by a power-of-two ratio. Occupancy is kept in units of the narrower width, so full/empty are
// exact. Drives the address/enable ports of a downstream asymmetric width converter, which
// returns read data one cycle after an accepted read.
//
// Ports:
//   clk_i         rising-edge clock
//   arst_n_i      asynchronous reset, active low
//   cke_i         clock enable, 0 freezes all state
//   rst_i         synchronous clear, qualified by cke_i
//   w_en_i        write request            w_full_o     write word cannot be accepted
//   r_en_i        read request             r_empty_o    no complete read word stored
//   r_valid_o     converter read data holds the word of the previous accepted read
//   level_o       occupancy in MINDATA_W units
//   overflow_o    one-cycle pulse per rejected write request
//   underflow_o   one-cycle pulse per rejected read request
//   mem_w_en_o / mem_w_addr_o   converter write port
//   mem_r_en_o / mem_r_addr_o   converter read port
module iob_asym_fifo_ctrl #(
  parameter int unsigned W_DATA_W = 21,
  parameter int unsigned R_DATA_W = 21,
  parameter int unsigned ADDR_W   = 3,
  localparam int unsigned MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int unsigned W_INCR    = W_DATA_W / MINDATA_W,
  localparam int unsigned R_INCR    = R_DATA_W / MINDATA_W,
  localparam int unsigned W_ADDR_W  = ADDR_W - $clog2(W_INCR),
  localparam int unsigned R_ADDR_W  = ADDR_W - $clog2(R_INCR)
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                w_en_i,
  output logic                w_full_o,
  input  logic                r_en_i,
  output logic                r_empty_o,
  output logic                r_valid_o,
  output logic [ADDR_W:0]     level_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                mem_w_en_o,
  output logic [W_ADDR_W-1:0] mem_w_addr_o,
  output logic                mem_r_en_o,
  output logic [R_ADDR_W-1:0] mem_r_addr_o
);

  localparam logic [ADDR_W+1:0] WIncrExt = (ADDR_W+2)'(W_INCR);
  localparam logic [ADDR_W+1:0] RIncrExt = (ADDR_W+2)'(R_INCR);
  // Full once there is no room left for a whole write word.
  localparam logic [ADDR_W:0]   FullThr  = (ADDR_W+1)'((1 << ADDR_W) - W_INCR);
  localparam logic [ADDR_W:0]   EmptyThr = (ADDR_W+1)'(R_INCR);

  logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                r_valid_q, r_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [ADDR_W+1:0]   level_sum;
  logic                unused_level_msb;
  logic                w_acc, r_acc;

  assign w_full_o  = level_q > FullThr;
  assign r_empty_o = level_q < EmptyThr;

  // Nothing is accepted while the asynchronous reset is held.
  assign w_acc = w_en_i & ~w_full_o & cke_i & arst_n_i;
  assign r_acc = r_en_i & ~r_empty_o & cke_i & arst_n_i;

  assign mem_w_en_o   = w_acc;
  assign mem_w_addr_o = w_ptr_q;
  assign mem_r_en_o   = r_acc;
  assign mem_r_addr_o = r_ptr_q;

  assign level_o     = level_q;
  assign r_valid_o   = r_valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // One extra bit of headroom; acceptance rules keep the result within 0..2^ADDR_W.
  assign level_sum = {1'b0, level_q} + (w_acc ? WIncrExt : '0) - (r_acc ? RIncrExt : '0);
  assign unused_level_msb = level_sum[ADDR_W+1];

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    level_d     = level_q;
    r_valid_d   = r_valid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (cke_i) begin
      if (rst_i) begin
        w_ptr_d     = '0;
        r_ptr_d     = '0;
        level_d     = '0;
        r_valid_d   = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (w_acc) w_ptr_d = w_ptr_q + W_ADDR_W'(1);
        if (r_acc) r_ptr_d = r_ptr_q + R_ADDR_W'(1);
        level_d     = level_sum[ADDR_W:0];
        r_valid_d   = r_acc;
        overflow_d  = w_en_i & w_full_o;
        underflow_d = r_en_i & r_empty_o;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      level_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      level_q     <= level_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Self-checking bench for iob_asym_fifo_ctrl. Two instances: a 32->8 narrowing FIFO (a_*) and an
// 8->32 widening FIFO (b_*), each with a small behavioural width converter attached. A queue of
// bytes models the FIFO contents; flags, level, addresses and read data are derived from it.
module tb_iob_asym_fifo_ctrl;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // Instance a: W=32, R=8, ADDR_W=4
  logic        a_cke, a_rst, a_w_en, a_r_en;
  logic        a_full, a_empty, a_rv, a_ov, a_ud, a_mwen, a_mren;
  logic [4:0]  a_level;
  logic [1:0]  a_waddr;
  logic [3:0]  a_raddr;
  logic [31:0] a_wdata;
  logic [7:0]  a_rdata;
  logic [7:0]  a_mem [16];

  // Instance b: W=8, R=32, ADDR_W=4
  logic        b_cke, b_rst, b_w_en, b_r_en;
  logic        b_full, b_empty, b_rv, b_ov, b_ud, b_mwen, b_mren;
  logic [4:0]  b_level;
  logic [3:0]  b_waddr;
  logic [1:0]  b_raddr;
  logic [7:0]  b_wdata;
  logic [31:0] b_rdata;
  logic [7:0]  b_mem [16];

  iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_dut_a (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .cke_i       (a_cke),
    .rst_i       (a_rst),
    .w_en_i      (a_w_en),
    .w_full_o    (a_full),
    .r_en_i      (a_r_en),
    .r_empty_o   (a_empty),
    .r_valid_o   (a_rv),
    .level_o     (a_level),
    .overflow_o  (a_ov),
    .underflow_o (a_ud),
    .mem_w_en_o  (a_mwen),
    .mem_w_addr_o(a_waddr),
    .mem_r_en_o  (a_mren),
    .mem_r_addr_o(a_raddr)
  );

  iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_dut_b (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .cke_i       (b_cke),
    .rst_i       (b_rst),
    .w_en_i      (b_w_en),
    .w_full_o    (b_full),
    .r_en_i      (b_r_en),
    .r_empty_o   (b_empty),
    .r_valid_o   (b_rv),
    .level_o     (b_level),
    .overflow_o  (b_ov),
    .underflow_o (b_ud),
    .mem_w_en_o  (b_mwen),
    .mem_w_addr_o(b_waddr),
    .mem_r_en_o  (b_mren),
    .mem_r_addr_o(b_raddr)
  );

  // Behavioural width converters, little-endian byte order within a wide word.
  always @(posedge clk) begin
    if (a_mwen) for (int i = 0; i < 4; i++) a_mem[{a_waddr, 2'(i)}] <= a_wdata[8*i +: 8];
    if (a_mren) a_rdata <= a_mem[a_raddr];
    if (b_mwen) b_mem[b_waddr] <= b_wdata;
    if (b_mren) b_rdata <= {b_mem[{b_raddr, 2'd3}], b_mem[{b_raddr, 2'd2}],
                            b_mem[{b_raddr, 2'd1}], b_mem[{b_raddr, 2'd0}]};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  mq [$];
  int          wcnt, rcnt;
  bit          e_rv, e_ov, e_ud;
  logic [31:0] e_word;
  int          sel;
  int          winc, rinc, wdepth, rdepth;

  task automatic model_clear();
    mq.delete();
    wcnt = 0;
    rcnt = 0;
    e_rv = 1'b0;
    e_ov = 1'b0;
    e_ud = 1'b0;
  endtask

  task automatic observe(output logic [31:0] lv, output logic [31:0] wa, output logic [31:0] ra,
                         output logic [31:0] rd, output logic f, output logic e,
                         output logic rv, output logic ov, output logic ud,
                         output logic mw, output logic mr);
    if (sel == 0) begin
      lv = 32'(a_level); wa = 32'(a_waddr); ra = 32'(a_raddr); rd = 32'(a_rdata);
      f = a_full; e = a_empty; rv = a_rv; ov = a_ov; ud = a_ud; mw = a_mwen; mr = a_mren;
    end else begin
      lv = 32'(b_level); wa = 32'(b_waddr); ra = 32'(b_raddr); rd = b_rdata;
      f = b_full; e = b_empty; rv = b_rv; ov = b_ov; ud = b_ud; mw = b_mwen; mr = b_mren;
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic cycle(input bit w, input bit r, input bit ce, input bit clr,
                       input logic [31:0] wd);
    logic [31:0] lv, wa, ra, rd;
    logic f, e, rv, ov, ud, mw, mr;
    int lvl;
    bit full, empty, wacc, racc;
    if (sel == 0) begin
      a_w_en = w; a_r_en = r; a_cke = ce; a_rst = clr; a_wdata = wd;
    end else begin
      b_w_en = w; b_r_en = r; b_cke = ce; b_rst = clr; b_wdata = wd[7:0];
    end
    @(negedge clk);
    observe(lv, wa, ra, rd, f, e, rv, ov, ud, mw, mr);
    lvl   = mq.size();
    full  = lvl > 16 - winc;
    empty = lvl < rinc;
    wacc  = w && !full && ce;
    racc  = r && !empty && ce;
    check_eq("level", lv, 32'(lvl));
    check_eq("w_full", 32'(f), 32'(full));
    check_eq("r_empty", 32'(e), 32'(empty));
    check_eq("mem_w_en", 32'(mw), 32'(wacc));
    check_eq("mem_r_en", 32'(mr), 32'(racc));
    check_eq("mem_w_addr", wa, 32'(wcnt % wdepth));
    check_eq("mem_r_addr", ra, 32'(rcnt % rdepth));
    check_eq("r_valid", 32'(rv), 32'(e_rv));
    check_eq("overflow", 32'(ov), 32'(e_ov));
    check_eq("underflow", 32'(ud), 32'(e_ud));
    if (e_rv) check_eq("r_data", rd, e_word);
    if (ce) begin
      if (clr) begin
        model_clear();
      end else begin
        e_ov = w && full;
        e_ud = r && empty;
        e_rv = racc;
        if (racc) begin
          e_word = '0;
          for (int i = 0; i < rinc; i++) e_word[8*i +: 8] = mq.pop_front();
          rcnt++;
        end
        if (wacc) begin
          for (int i = 0; i < winc; i++) mq.push_back(wd[8*i +: 8]);
          wcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert the asynchronous reset between clock edges with requests pending.
  task automatic async_reset();
    logic [31:0] lv, wa, ra, rd;
    logic f, e, rv, ov, ud, mw, mr;
    if (sel == 0) begin a_w_en = 1'b1; a_r_en = 1'b1; a_cke = 1'b1; a_rst = 1'b0; end
    else          begin b_w_en = 1'b1; b_r_en = 1'b1; b_cke = 1'b1; b_rst = 1'b0; end
    #2 arst_n = 1'b0;
    #1;
    observe(lv, wa, ra, rd, f, e, rv, ov, ud, mw, mr);
    check_eq("rst_level", lv, 32'd0);
    check_eq("rst_empty", 32'(e), 32'd1);
    check_eq("rst_full", 32'(f), 32'd0);
    check_eq("rst_mem_w_en", 32'(mw), 32'd0);
    check_eq("rst_mem_r_en", 32'(mr), 32'd0);
    check_eq("rst_r_valid", 32'(rv), 32'd0);
    check_eq("rst_overflow", 32'(ov), 32'd0);
    check_eq("rst_underflow", 32'(ud), 32'd0);
    a_w_en = 1'b0; a_r_en = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0;
    model_clear();
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [31:0] word;

  initial begin
    arst_n = 1'b0;
    a_cke = 1'b1; a_rst = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0; a_wdata = '0;
    b_cke = 1'b1; b_rst = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; b_wdata = '0;
    sel = 0; winc = 4; rinc = 1; wdepth = 4; rdepth = 16;
    model_clear();
    e_word = '0;
    #12 arst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 0, 1, 0, 0);

    // Five writes (the fifth finds the FIFO full), then reset mid-cycle.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 32'h1000_0000 + 32'(i));
    async_reset();
    cycle(0, 0, 1, 0, 0);

    // Fill with four wide words, then a rejected fifth.
    cycle(1, 0, 1, 0, 32'h4433_2211);
    cycle(1, 0, 1, 0, 32'h8877_6655);
    cycle(1, 0, 1, 0, 32'hccbb_aa99);
    cycle(1, 0, 1, 0, 32'h00ff_eedd);
    check_eq("fill_level", 32'(a_level), 32'd16);
    cycle(1, 0, 1, 0, 32'hdead_beef);
    cycle(0, 0, 1, 0, 0);
    check_eq("fill_hold", 32'(a_level), 32'd16);

    // Drain sixteen bytes, then a rejected seventeenth read.
    for (int i = 0; i < 17; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check_eq("drain_level", 32'(a_level), 32'd0);

    // Simultaneous access at level 8, then at level 16.
    cycle(1, 0, 1, 0, 32'h0403_0201);
    cycle(1, 0, 1, 0, 32'h0807_0605);
    cycle(1, 1, 1, 0, 32'h0c0b_0a09);
    check_eq("simul_lvl8", 32'(a_level), 32'd11);
    cycle(1, 0, 1, 0, 32'h100f_0e0d);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 32'h1413_1211);
    check_eq("simul_full_pre", 32'(a_level), 32'd16);
    cycle(1, 1, 1, 0, 32'h5555_5555);
    check_eq("simul_lvl16", 32'(a_level), 32'd15);
    for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Three fill/drain rounds with an incrementing byte pattern.
    pat = 8'h20;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 4; i++) begin
        word = {pat + 8'd3, pat + 8'd2, pat + 8'd1, pat};
        cycle(1, 0, 1, 0, word);
        pat = pat + 8'd4;
      end
      for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
    end

    // Synchronous clear overriding a write.
    cycle(1, 0, 1, 0, 32'h0a0b_0c0d);
    cycle(1, 0, 1, 1, 32'h0e0f_1011);
    check_eq("sync_clear", 32'(a_level), 32'd0);
    cycle(0, 0, 1, 0, 0);

    // Random traffic on the narrowing instance.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(7) != 0),
            ($urandom_range(63) == 0), $urandom);

    // Switch to the widening instance.
    a_w_en = 1'b0; a_r_en = 1'b0; a_cke = 1'b1; a_rst = 1'b0;
    sel = 1; winc = 1; rinc = 4; wdepth = 16; rdepth = 4;
    async_reset();
    cycle(0, 0, 1, 0, 0);

    // Reads at levels 1..3 are rejected; at level 4 one read empties the FIFO.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 0, 32'(8'h31 + 8'(i)));
      cycle(0, 1, 1, 0, 0);
    end
    cycle(1, 0, 1, 0, 32'h34);
    check_eq("rev_lvl4", 32'(b_level), 32'd4);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check_eq("rev_lvl0", 32'(b_level), 32'd0);

    // Clock enable low with both requests pending.
    cycle(1, 0, 1, 0, 32'h41);
    cycle(1, 0, 1, 0, 32'h42);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 32'h99);
    check_eq("cke_hold", 32'(b_level), 32'd2);
    cycle(0, 0, 1, 0, 0);

    // Random traffic on the widening instance.
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(7) != 0),
            ($urandom_range(63) == 0), $urandom);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
